// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings and the F/D pipeline register type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } fd_reg_t;

    localparam fd_reg_t FD_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  64'd0,
        valp:  64'd0
    };

endpackage

`default_nettype wire

// File: rtl/fetch_decode.sv
// ============================================================================
// Module      : fetch_decode
// Description : Combinational decode of a 10-byte instruction window: fields,
//               length, status and next-PC prediction. Backward-taken /
//               forward-not-taken prediction enabled by FETCH_BTFN_PRED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_decode
    import y86_pkg::*;
(
    input  logic [63:0] pc,
    input  logic [79:0] win,       // byte i of the window at [8*i +: 8]
    input  logic [9:0]  byte_oob,  // byte i lies outside instruction memory
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic [2:0]  stat,
    output logic [63:0] pred_pc
);

    logic       w_need_regids;
    logic       w_need_valc;
    logic       w_instr_valid;
    logic       w_imem_error;
    logic [3:0] w_len;
    logic [9:0] w_len_mask;

    always_comb begin
        icode = win[7:4];
        ifun  = win[3:0];

        w_need_regids = icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ};
        w_need_valc   = icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ, IJXX, ICALL};

        w_len = 4'd1 + {3'd0, w_need_regids} + (w_need_valc ? 4'd8 : 4'd0);
        // Out-of-range bytes only matter when they belong to this instruction.
        for (int i = 0; i < 10; i++) begin
            w_len_mask[i] = (4'(i) < w_len);
        end
        w_imem_error = |(byte_oob & w_len_mask);

        ra = w_need_regids ? win[15:12] : RNONE;
        rb = w_need_regids ? win[11:8]  : RNONE;

        // Constant is stored with the lowest address as the most significant byte.
        valc = 64'd0;
        if (w_need_valc) begin
            for (int k = 0; k < 8; k++) begin
                valc[63-8*k -: 8] = w_need_regids ? win[8*(k+2) +: 8] : win[8*(k+1) +: 8];
            end
        end

        valp = pc + {60'd0, w_len};

        case (icode)
            IRRMOVQ, IJXX: w_instr_valid = (ifun <= 4'd6);
            IOPQ:          w_instr_valid = (ifun <= 4'd3);
            IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            ICALL, IRET, IPUSHQ, IPOPQ:
                           w_instr_valid = (ifun == 4'd0);
            default:       w_instr_valid = 1'b0;
        endcase

        if (w_imem_error)        stat = SADR;
        else if (!w_instr_valid) stat = SINS;
        else if (icode == IHALT) stat = SHLT;
        else                     stat = SAOK;

`ifdef FETCH_BTFN_PRED_EN
        if (icode == IJXX && ifun != 4'd0) pred_pc = (valc < pc) ? valc : valp;
        else if (icode == IJXX || icode == ICALL) pred_pc = valc;
        else pred_pc = valp;
`else
        pred_pc = (icode == IJXX || icode == ICALL) ? valc : valp;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/pipe_fetch.sv
// ============================================================================
// Module      : pipe_fetch
// Description : Y86-64 pipeline fetch stage: instruction byte memory with load
//               port, PC select, F_predPC and F/D register. FETCH_BTFN_PRED_EN
//               selects backward-taken conditional-jump prediction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_fetch
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 512,
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IADDR_W    = $clog2(IMEM_BYTES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               imem_we,
    input  logic [IADDR_W-1:0] imem_waddr,
    input  logic [7:0]         imem_wdata,
    input  logic               F_stall,
    input  logic               D_stall,
    input  logic               D_bubble,
    input  logic               M_mispredict,
    input  logic [63:0]        M_valA,
    input  logic               W_ret,
    input  logic [63:0]        W_valM,
    output logic [63:0]        f_pc,
    output logic [2:0]         D_stat,
    output logic [3:0]         D_icode,
    output logic [3:0]         D_ifun,
    output logic [3:0]         D_rA,
    output logic [3:0]         D_rB,
    output logic [63:0]        D_valC,
    output logic [63:0]        D_valP
);

    logic [7:0]  r_mem [0:IMEM_BYTES-1];
    logic [63:0] r_pred_pc;
    fd_reg_t     r_fd;

    logic [79:0] w_win;
    logic [9:0]  w_oob;
    logic [63:0] w_pred_next;
    fd_reg_t     w_fd_dec;

    always_comb begin
        if (M_mispredict) f_pc = M_valA;
        else if (W_ret)   f_pc = W_valM;
        else              f_pc = r_pred_pc;
    end

    // Writes land on the edge, so a same-cycle fetch still sees the old byte.
    always_ff @(posedge clk) begin
        if (imem_we) r_mem[imem_waddr] <= imem_wdata;
    end

    for (genvar g = 0; g < 10; g++) begin : g_byte
        logic [63:0] w_addr;
        assign w_addr         = f_pc + 64'(g);
        assign w_oob[g]       = (w_addr >= 64'(IMEM_BYTES));
        assign w_win[8*g +: 8] = w_oob[g] ? 8'h00 : r_mem[w_addr[IADDR_W-1:0]];
    end

    fetch_decode u_decode (
        .pc       (f_pc),
        .win      (w_win),
        .byte_oob (w_oob),
        .icode    (w_fd_dec.icode),
        .ifun     (w_fd_dec.ifun),
        .ra       (w_fd_dec.ra),
        .rb       (w_fd_dec.rb),
        .valc     (w_fd_dec.valc),
        .valp     (w_fd_dec.valp),
        .stat     (w_fd_dec.stat),
        .pred_pc  (w_pred_next)
    );

    always_ff @(posedge clk) begin
        if (reset)         r_pred_pc <= RESET_PC;
        else if (!F_stall) r_pred_pc <= w_pred_next;
    end

    // Stall outranks bubble when both are requested.
    always_ff @(posedge clk) begin
        if (reset)          r_fd <= FD_BUBBLE;
        else if (D_stall)   r_fd <= r_fd;
        else if (D_bubble)  r_fd <= FD_BUBBLE;
        else                r_fd <= w_fd_dec;
    end

    assign D_stat  = r_fd.stat;
    assign D_icode = r_fd.icode;
    assign D_ifun  = r_fd.ifun;
    assign D_rA    = r_fd.ra;
    assign D_rB    = r_fd.rb;
    assign D_valC  = r_fd.valc;
    assign D_valP  = r_fd.valp;

endmodule

`default_nettype wire

// File: tb/tb_pipe_fetch.sv
// ============================================================================
// Module      : tb_pipe_fetch
// Description : Scoreboard bench for pipe_fetch with a byte-level fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_fetch;

    localparam int          IMEM = 512;
    localparam logic [63:0] RPC  = 64'd10;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    localparam dreg_t BUB = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                              valc: 64'd0, valp: 64'd0};

    logic        clk = 1'b0;
    logic        reset, imem_we;
    logic [8:0]  imem_waddr;
    logic [7:0]  imem_wdata;
    logic        F_stall, D_stall, D_bubble, M_mispredict, W_ret;
    logic [63:0] M_valA, W_valM;
    logic [63:0] f_pc;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    pipe_fetch #(.IMEM_BYTES(IMEM), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .M_mispredict(M_mispredict), .M_valA(M_valA),
        .W_ret(W_ret), .W_valM(W_valM), .f_pc(f_pc), .D_stat(D_stat),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    dreg_t       fd_q[$];
    logic [63:0] pc_q[$];
    logic [7:0]  m_mem [IMEM];
    logic [63:0] m_pred;
    dreg_t       m_d;
    bit          pc_known = 0;

    // Reference fetch: instruction bytes, length and status straight from the ISA rules.
    function automatic void ref_fetch(input logic [63:0] pc, output dreg_t d, output logic [63:0] pred);
        logic [7:0]  b [10];
        bit          oob [10];
        logic [63:0] a;
        bit          regs, cst, err, valid;
        int          len, off;
        for (int i = 0; i < 10; i++) begin
            a      = pc + 64'(i);
            oob[i] = (a >= 64'(IMEM));
            b[i]   = oob[i] ? 8'h00 : m_mem[a[8:0]];
        end
        d.icode = b[0][7:4];
        d.ifun  = b[0][3:0];
        regs = d.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        cst  = d.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        len  = 1 + (regs ? 1 : 0) + (cst ? 8 : 0);
        err  = 0;
        for (int i = 0; i < len; i++) if (oob[i]) err = 1;
        if (d.icode > 4'hB)                      valid = 0;
        else if (d.icode inside {4'h2, 4'h7})    valid = (d.ifun <= 4'd6);
        else if (d.icode == 4'h6)                valid = (d.ifun <= 4'd3);
        else                                     valid = (d.ifun == 4'd0);
        d.ra = regs ? b[1][7:4] : 4'hF;
        d.rb = regs ? b[1][3:0] : 4'hF;
        off  = regs ? 2 : 1;
        d.valc = 64'd0;
        if (cst) for (int k = 0; k < 8; k++) d.valc = {d.valc[55:0], b[off+k]};
        d.valp = pc + 64'(len);
        d.stat = err ? 3'd3 : (!valid ? 3'd4 : (d.icode == 4'h0 ? 3'd2 : 3'd1));
        pred = (d.icode == 4'h7 || d.icode == 4'h8) ? d.valc : d.valp;
`ifdef FETCH_BTFN_PRED_EN
        if (d.icode == 4'h7 && d.ifun != 4'h0 && !(d.valc < pc)) pred = d.valp;
`endif
    endfunction

    // Issue one cycle: model the edge from the inputs currently driven.
    task automatic tick();
        logic [63:0] fpc, pred;
        dreg_t       dec;
        fpc = M_mispredict ? M_valA : (W_ret ? W_valM : m_pred);
        if (pc_known) pc_q.push_back(fpc);
        ref_fetch(fpc, dec, pred);
        if (reset)         m_d = BUB;
        else if (!D_stall) m_d = D_bubble ? BUB : dec;
        fd_q.push_back(m_d);
        if (reset)         m_pred = RPC;
        else if (!F_stall) m_pred = pred;
        if (reset) pc_known = 1;
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 0; imem_we = 0; imem_waddr = '0; imem_wdata = '0;
        F_stall = 0; D_stall = 0; D_bubble = 0;
        M_mispredict = 0; M_valA = '0; W_ret = 0; W_valM = '0;
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        imem_we = 1; imem_waddr = 9'(addr); imem_wdata = data;
        tick();
        imem_we = 0;
    endtask

    task automatic redirect(input logic [63:0] pc);
        M_mispredict = 1; M_valA = pc;
        tick();
        M_mispredict = 0;
    endtask

    task automatic spot(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rand_byte();
        return {4'($urandom_range(0, 12)), 4'($urandom_range(0, 7))};
    endfunction

    function automatic logic [63:0] rand_pc();
        if ($urandom_range(0, 9) == 0) return {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
        return 64'($urandom_range(0, IMEM + 10));
    endfunction

    // F/D monitor
    initial begin
        dreg_t act, exp;
        forever begin
            @(posedge clk); #1;
            if (fd_q.size() > 0) begin
                exp = fd_q.pop_front();
                act = '{stat: D_stat, icode: D_icode, ifun: D_ifun, ra: D_rA, rb: D_rB,
                        valc: D_valC, valp: D_valP};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL fd_reg t=%0t act=%0d/%h/%h/%h/%h/%h/%h exp=%0d/%h/%h/%h/%h/%h/%h",
                             $time, act.stat, act.icode, act.ifun, act.ra, act.rb, act.valc, act.valp,
                             exp.stat, exp.icode, exp.ifun, exp.ra, exp.rb, exp.valc, exp.valp);
                end
            end
        end
    end

    // f_pc monitor
    initial begin
        logic [63:0] exp;
        forever begin
            @(negedge clk); #2;
            if (pc_q.size() > 0) begin
                exp = pc_q.pop_front();
                total++;
                if (f_pc !== exp) begin
                    bad++;
                    $display("FAIL f_pc t=%0t act=%0h exp=%0h", $time, f_pc, exp);
                end
            end
        end
    end

    initial begin
        set_idle();
        reset = 1;
        for (int a = 0; a < IMEM; a++) wr(a, rand_byte());
        begin
            logic [7:0] prog_mr [10] = '{8'h50, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
            logic [7:0] prog_j  [9]  = '{8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
            logic [7:0] prog_jl [9]  = '{8'h71, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
            for (int i = 0; i < 10; i++) wr(10 + i, prog_mr[i]);
            for (int i = 0; i < 9; i++)  wr(20 + i, prog_j[i]);
            for (int i = 0; i < 9; i++)  wr(40 + i, prog_jl[i]);
        end
        wr(29, 8'h60); wr(30, 8'h01);
        wr(0, 8'h63);  wr(1, 8'h12);
        wr(511, 8'h30);

        // mrmovq at RESET_PC
        set_idle();
        tick();
        spot("mr_icode", 64'(D_icode), 64'd5);
        spot("mr_ra",    64'(D_rA),    64'd0);
        spot("mr_rb",    64'(D_rB),    64'd2);
        spot("mr_valc",  D_valC,       64'h10);
        spot("mr_valp",  D_valP,       64'd20);
        spot("mr_stat",  64'(D_stat),  64'd1);
        tick();
        spot("jmp_valc", D_valC, 64'h10);
        #1 spot("jmp_pred", f_pc, 64'd16);
        redirect(64'd29);
        spot("add_valp", D_valP, 64'd31);

        redirect(64'd0);
        spot("cmov_stat", 64'(D_stat), 64'd1);
        spot("cmov_valp", D_valP, 64'd2);
        wr(3, 8'hC0);
        redirect(64'd3);
        spot("ins_stat", 64'(D_stat), 64'd4);
        wr(0, 8'h00);
        redirect(64'd0);
        spot("hlt_stat", 64'(D_stat), 64'd2);
        spot("hlt_valp", D_valP, 64'd1);
        redirect(64'(IMEM - 1));
        spot("adr_stat", 64'(D_stat), 64'd3);

        // stall / bubble interplay
        redirect(64'd10);
        D_stall = 1; D_bubble = 1;
        redirect(64'd29);
        spot("stall_wins", 64'(D_icode), 64'd5);
        D_stall = 0;
        tick();
        spot("bub_icode", 64'(D_icode), 64'd1);
        spot("bub_stat",  64'(D_stat),  64'd1);
        D_bubble = 0;
        redirect(64'd10);
        F_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 spot("fstall_hold", f_pc, 64'd20);
            tick();
        end
        F_stall = 0;
        W_ret = 1; W_valM = 64'd29;
        tick();
        M_mispredict = 1; M_valA = 64'd10;
        tick();
        set_idle();

        // conditional jump, backward then forward target
        redirect(64'd40);
        #1 spot("jle_back", f_pc, 64'd16);
        wr(48, 8'h64);
        redirect(64'd40);
`ifdef FETCH_BTFN_PRED_EN
        #1 spot("jle_fwd", f_pc, 64'd49);
`else
        #1 spot("jle_fwd", f_pc, 64'd100);
`endif

        // mid-run reset, then randomized traffic
        F_stall = 1; D_stall = 1; reset = 1;
        tick();
        set_idle();
        #1 spot("post_reset_pc", f_pc, RPC);
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 60) == 0);
            imem_we      = ($urandom_range(0, 3) == 0);
            imem_waddr   = 9'($urandom_range(0, IMEM - 1));
            imem_wdata   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rand_byte();
            F_stall      = ($urandom_range(0, 7) == 0);
            D_stall      = ($urandom_range(0, 7) == 0);
            D_bubble     = ($urandom_range(0, 7) == 0);
            M_mispredict = ($urandom_range(0, 5) == 0);
            M_valA       = rand_pc();
            W_ret        = ($urandom_range(0, 7) == 0);
            W_valM       = rand_pc();
            tick();
        end
        set_idle();
        tick();
        #5;
        spot("queues_drained", 64'(fd_q.size() + pc_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
